// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizing,
// address-width helper and the write-port priority resolver used by both
// the storage update and the read bypass path.
package regfile_pkg;

  localparam int DEF_DW     = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 4;
  localparam int DEF_NUM_WR = 2;

  // Upper bound on write ports handled by the resolver; NUM_WR must not exceed it.
  localparam int MAX_WR = 16;
  localparam int WR_IW  = 4;

  // Result of write-port resolution: whether any port hit, and which one wins.
  typedef struct packed {
    logic             hit;
    logic [WR_IW-1:0] idx;
  } wr_sel_t;

  // Address width for a given depth; never below 1 so a 1-entry file still has a port.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Highest-index set bit of the match vector wins, so later ports override earlier ones.
  function automatic wr_sel_t wr_resolve(input logic [MAX_WR-1:0] match);
    wr_sel_t sel;
    sel = '0;
    for (int j = 0; j < MAX_WR; j++) begin
      if (match[j]) begin
        sel.hit = 1'b1;
        sel.idx = WR_IW'(j);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: register select, optional same-cycle write bypass,
// register-0 / out-of-range masking and the per-port busy indication.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = clog2(DEF_DEPTH),
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                 rst_n_i,
  input  logic [AW-1:0]        raddr_i,
  input  logic [DEPTH*DW-1:0]  regs_i,
  input  logic [DEPTH-1:0]     busy_i,
  input  logic [NUM_WR-1:0]    we_i,
  input  logic [NUM_WR*AW-1:0] waddr_i,
  input  logic [NUM_WR*DW-1:0] wdata_i,
  input  logic                 issue_i,
  input  logic [AW-1:0]        issue_addr_i,
  output logic [DW-1:0]        rdata_o,
  output logic                 rbusy_o
);

  // Combinational read: stored value, overridden by the winning write port when bypassing, then masked.
  always_comb begin
    logic [MAX_WR-1:0] match;
    wr_sel_t           sel;
    logic [DW-1:0]     stored;
    logic [DW-1:0]     fwd;
    logic              stored_busy;
    logic              in_range;
    logic              masked;
    logic              issued;

    match       = '0;
    stored      = '0;
    fwd         = '0;
    stored_busy = 1'b0;

    for (int a = 0; a < DEPTH; a++) begin
      if (raddr_i == AW'(a)) begin
        stored      = regs_i[a*DW +: DW];
        stored_busy = busy_i[a];
      end
    end

    for (int j = 0; j < NUM_WR; j++) begin
      match[j] = we_i[j] && (waddr_i[j*AW +: AW] == raddr_i);
    end
    sel = wr_resolve(match);

    for (int j = 0; j < NUM_WR; j++) begin
      if (int'(sel.idx) == j) fwd = wdata_i[j*DW +: DW];
    end

    in_range = int'(raddr_i) < DEPTH;
    masked   = !rst_n_i || !in_range || ((ZERO_REG != 0) && (raddr_i == '0));
    issued   = issue_i && (issue_addr_i == raddr_i);

    rdata_o = stored;
    rbusy_o = stored_busy;
    // A write landing this cycle retires the pending producer unless a new one is issued alongside.
    if ((BYPASS != 0) && sel.hit) begin
      rdata_o = fwd;
      if (!issued) rbusy_o = 1'b0;
    end
    if (masked) begin
      rdata_o = '0;
      rbusy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard. Storage and scoreboard
// live here; each read port is an instance of regfile_rd_port.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = clog2(DEPTH),
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NUM_RD*AW-1:0] raddr_i,
  output logic [NUM_RD*DW-1:0] rdata_o,
  output logic [NUM_RD-1:0]    rbusy_o,
  input  logic [NUM_WR-1:0]    we_i,
  input  logic [NUM_WR*AW-1:0] waddr_i,
  input  logic [NUM_WR*DW-1:0] wdata_i,
  input  logic                 issue_i,
  input  logic [AW-1:0]        issue_addr_i,
  output logic [DEPTH-1:0]     busy_o
);

  logic [DW-1:0]       regs_q [DEPTH];
  logic [DW-1:0]       regs_d [DEPTH];
  logic [DEPTH-1:0]    busy_q;
  logic [DEPTH-1:0]    busy_d;
  logic [DEPTH*DW-1:0] regs_flat;

  // Next state per register: winning write port updates data and clears busy; an issue then sets busy.
  always_comb begin
    logic [MAX_WR-1:0] match;
    wr_sel_t           sel;
    logic              locked;

    match  = '0;
    sel    = '0;
    locked = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      regs_d[a] = regs_q[a];
      busy_d[a] = busy_q[a];
      locked    = (ZERO_REG != 0) && (a == 0);
      match     = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        match[j] = we_i[j] && (waddr_i[j*AW +: AW] == AW'(a));
      end
      sel = wr_resolve(match);
      if (sel.hit && !locked) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (int'(sel.idx) == j) regs_d[a] = wdata_i[j*DW +: DW];
        end
        busy_d[a] = 1'b0;
      end
      // Issue after write: a freshly issued producer keeps the register busy.
      if (issue_i && (issue_addr_i == AW'(a)) && !locked) busy_d[a] = 1'b1;
    end
  end

  // State registers; asynchronous reset drops any in-flight write or issue.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int a = 0; a < DEPTH; a++) regs_q[a] <= '0;
      busy_q <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) regs_q[a] <= regs_d[a];
      busy_q <= busy_d;
    end
  end

  // Flatten storage so every read port can see all registers.
  always_comb begin
    regs_flat = '0;
    for (int a = 0; a < DEPTH; a++) regs_flat[a*DW +: DW] = regs_q[a];
  end

  assign busy_o = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .NUM_WR   (NUM_WR),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .rst_n_i      (rst_n_i),
      .raddr_i      (raddr_i[k*AW +: AW]),
      .regs_i       (regs_flat),
      .busy_i       (busy_q),
      .we_i         (we_i),
      .waddr_i      (waddr_i),
      .wdata_i      (wdata_i),
      .issue_i      (issue_i),
      .issue_addr_i (issue_addr_i),
      .rdata_o      (rdata_o[k*DW +: DW]),
      .rbusy_o      (rbusy_o[k])
    );
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined CPU datapath, the successor to the single-write, dual-read register bank. It gives a configurable number of read and write ports and an optional same-cycle write-to-read bypass. Register 0 is hardwired to zero. A per-register busy scoreboard lets the hazard unit stall on pending writebacks. It sits between decode (read/issue) and writeback (write/clear).

## Interface
Parameters:
- DW, 32, data width of each register
- DEPTH, 32, number of registers
- AW, $clog2(DEPTH), address width (derived, do not override)
- NUM_RD, 4, number of read ports
- NUM_WR, 2, number of write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see only stored state
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/issues

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- raddr_i  in  NUM_RD*AW  read addresses, port k at bits [k*AW +: AW]
- rdata_o  out  NUM_RD*DW  read data, combinational
- rbusy_o  out  NUM_RD  busy bit of each addressed register, combinational
- we_i  in  NUM_WR  write enables
- waddr_i  in  NUM_WR*AW  write addresses
- wdata_i  in  NUM_WR*DW  write data
- issue_i  in  1  mark issue_addr_i busy (destination of a newly issued instruction)
- issue_addr_i  in  AW  register to mark busy
- busy_o  out  DEPTH  full scoreboard vector, registered

## Operation
- Reset (rst_n_i low, asynchronous): all registers clear to 0, all busy bits clear to 0. rdata_o and rbusy_o are 0 while reset is asserted. busy_o is 0.
- Write: on each rising edge, for every port j with we_i[j]=1, register waddr_j takes wdata_j and its busy bit clears.
- Write conflict: several ports writing the same address in one cycle resolves to the highest-index port.
- Issue: issue_i=1 sets busy[issue_addr_i] on the next edge.
- Issue and write to the same register in the same cycle: the set wins and the busy bit ends at 1, because the new producer is still outstanding. The data write still occurs.
- Read: rdata_o[k] = register[raddr_k].
  - With BYPASS=1, if any write port targets raddr_k with we=1 in the current cycle, the highest-index such port's wdata is returned instead.
  - With BYPASS=1, rbusy_o[k] reads 0 when raddr_k is being written this cycle and not simultaneously issued. Otherwise it is busy[raddr_k].
- Register 0 with ZERO_REG=1: always reads 0, never busy. Writes and issues to it are ignored, including for bypass.
- Out-of-range address (DEPTH not a power of two):
  - reads return 0 with rbusy 0
  - writes and issues are dropped

## Timing
- Read latency is 0 cycles (combinational from raddr_i, we_i, waddr_i, wdata_i).
- Write-to-read:
  - BYPASS=1: visible in the same cycle.
  - BYPASS=0: visible the cycle after the edge.
- Issue-to-busy: rbusy_o and busy_o assert 1 cycle after issue_i.
- Writeback clear: busy drops on the edge that captures the write.
- Reset deassertion: the first state update happens on the first rising edge after rst_n_i goes high.
- Reset asserted mid-operation: the in-flight write and issue are lost and all state clears immediately.

## Structure
- Shared package regfile_pkg holds:
  - default DW, DEPTH, NUM_RD, NUM_WR
  - function clog2 for AW
  - the write-priority resolve function (highest-index match), shared by the storage write and the bypass path
- Sub-module regfile_rd_port (instantiated NUM_RD times in a generate loop) covers one port's read mux, bypass select, zero/out-of-range masking and rbusy logic.
- Storage and the scoreboard stay in the top module.

## Test plan
- Reset, then read all addresses: every rdata 0, busy_o = 0; assert rst_n_i mid-write of 0xDEADBEEF to r5: r5 stays 0.
- Write 0x1234_5678 to r3 on port 0 while reading r3, with BYPASS=1: rdata 0x1234_5678 in the same cycle. With BYPASS=0: old value 0 in that cycle, new value the next cycle.
- Ports 0 and 1 both write r7, with 0xAAAA and 0xBBBB: r7 = 0xBBBB, and the bypass also returns 0xBBBB.
- Write 0xFFFF_FFFF to r0 and issue r0: r0 reads 0, busy_o[0] stays 0.
- Scoreboard sequence:
  - issue r9: rbusy 1 the next cycle
  - write r9: busy clears the following cycle, and rbusy reads 0 in the write cycle with BYPASS=1
  - issue and write r9 together: busy_o[9] = 1 afterwards
- DEPTH=24: write to address 30 dropped and read of 30 returns 0; all 4 read ports read distinct registers concurrently and match the values written.
